// File: rtl/gf_inv_fermat_engine_pkg.sv
// +----------------------------------------------------------------------------+
// | gf_pkg : shared field constants and FSM encoding for the GF(2^m) inverter   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package gf_pkg;

  localparam int          GF_M    = 16;
  localparam logic [15:0] GF_POLY = 16'h002D;
  localparam logic [15:0] GF_ONE  = 16'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gf_mul_comb.sv
// +----------------------------------------------------------------------------+
// | gf_mul_comb : combinational m x m GF(2^m) multiplier, reduced mod x^m+POLY  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf_mul_comb #(
  parameter int           m    = 16,
  parameter logic [m-1:0] POLY = 16'h002D
) (
  input  logic [m-1:0] a_i,
  input  logic [m-1:0] b_i,
  output logic [m-1:0] p_o
);

  logic [2*m-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < m; i++) begin
      if (b_i[i]) w_acc = w_acc ^ ({{m{1'b0}}, a_i} << i);
    end
    // Fold high terms down, top bit first, using x^m == POLY.
    for (int i = 2*m-2; i >= m; i--) begin
      if (w_acc[i]) begin
        w_acc    = w_acc ^ ({{m{1'b0}}, POLY} << (i - m));
        w_acc[i] = 1'b0;
      end
    end
  end

  assign p_o = w_acc[m-1:0];

endmodule

`default_nettype wire

// File: rtl/gf_inv_fermat_engine.sv
// +----------------------------------------------------------------------------+
// | gf_inv_fermat_engine : a^-1 = a^(2^m-2) by m-1 square-and-multiply steps.   |
// | Optional zero-operand shortcut/flag: GF_INV_ZERO_DETECT_EN. Rev 1.0         |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf_inv_fermat_engine
  import gf_pkg::*;
#(
  parameter int           m    = GF_M,
  parameter logic [m-1:0] POLY = GF_POLY[m-1:0]
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [m-1:0] a_in,
  output logic         busy,
  output logic         done,
  output logic [m-1:0] inv_out,
  output logic         err
);

  localparam int            CNT_W  = $clog2(m);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(m - 2);

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [m-1:0]     inv_q;
  logic [CNT_W-1:0] cnt_q;
  logic [m-1:0]     s_q;
  logic [m-1:0]     r_q;
  logic [m-1:0]     w_sq;
  logic [m-1:0]     w_prod;

  gf_mul_comb #(.m(m), .POLY(POLY)) u_sq (
    .a_i (s_q),
    .b_i (s_q),
    .p_o (w_sq)
  );

  // r is multiplied by the freshly squared s, so after step k r = a^(2+4+..+2^k).
  gf_mul_comb #(.m(m), .POLY(POLY)) u_mul (
    .a_i (r_q),
    .b_i (w_sq),
    .p_o (w_prod)
  );

`ifdef GF_INV_ZERO_DETECT_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      inv_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
`ifdef GF_INV_ZERO_DETECT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            s_q     <= a_in;
            r_q     <= m'(GF_ONE);
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
`ifdef GF_INV_ZERO_DETECT_EN
            err_q   <= 1'b0;
            if (a_in == '0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              inv_q   <= '0;
              err_q   <= 1'b1;
            end
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q   <= w_sq;
          r_q   <= w_prod;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == c_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            inv_q   <= w_prod;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign inv_out = inv_q;

endmodule

`default_nettype wire
